// File: rtl/gshare_bht.sv
// gshare_bht: branch history table of saturating counters, indexed by PC
// (bimodal) or PC XOR global history (gshare). Split predict/update ports,
// one-cycle registered prediction, non-speculative history, and saturating
// update / mispredict statistics.
module gshare_bht #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int PC_W      = 9,
    parameter int HIST_BITS = 4,
    parameter int MODE      = 1,
    parameter int STAT_W    = 16,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic [PC_W-1:0]      pred_pc,
    output logic                 pred_out_valid,
    output logic                 prediction,
    output logic [IDX_W-1:0]     pred_idx,
    input  logic                 upd_valid,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic [HIST_BITS-1:0] ghr,
    output logic [STAT_W-1:0]    stat_updates,
    output logic [STAT_W-1:0]    stat_mispredicts
);

    // Weakly not-taken start value (zero for single-bit counters).
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    // Upper PC bits never take part in indexing.
    generate
        if (PC_W > IDX_W) begin : g_pc_upper
            logic unused_pc_bits;
            assign unused_pc_bits = ^pred_pc[PC_W-1:IDX_W];
        end
    endgenerate

    logic [IDX_W-1:0] hist_ext;
    logic [IDX_W-1:0] idx;
    logic [ENTRIES-1:0] ctr_msb;

    // History is zero-extended to the index width; bimodal mode ignores it.
    assign hist_ext = IDX_W'(ghr);
    assign idx      = pred_pc[IDX_W-1:0] ^ ((MODE == 1) ? hist_ext : '0);

    // One saturating counter per entry; only its MSB feeds the prediction.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            logic [CTR_BITS-1:0] ctr_reg;

            // Saturating increment/decrement when this entry is the update target.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ctr_reg <= CTR_INIT;
                end else if (upd_valid && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        if (ctr_reg != CTR_MAX) ctr_reg <= ctr_reg + 1'b1;
                    end else begin
                        if (ctr_reg != '0) ctr_reg <= ctr_reg - 1'b1;
                    end
                end
            end

            assign ctr_msb[gi] = ctr_reg[CTR_BITS-1];
        end
    endgenerate

    // Registered prediction; reads pre-edge table and history (no bypass).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_out_valid <= 1'b0;
            prediction     <= 1'b0;
            pred_idx       <= '0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                prediction <= ctr_msb[idx];
                pred_idx   <= idx;
            end
        end
    end

    // Global history shifts in resolved outcomes only.
    generate
        if (HIST_BITS == 1) begin : g_ghr_one
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)         ghr <= '0;
                else if (upd_valid) ghr <= upd_taken;
            end
        end else begin : g_ghr_shift
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)         ghr <= '0;
                else if (upd_valid) ghr <= {ghr[HIST_BITS-2:0], upd_taken};
            end
        end
    endgenerate

    // Accuracy statistics, saturating at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            if (stat_updates != '1)
                stat_updates <= stat_updates + 1'b1;
            if (upd_mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: drives a gshare instance (MODE=1) and a bimodal instance
// (MODE=0, STAT_W=4) with identical stimulus and checks both against a
// behavioural table model every cycle, plus directed literal expectations.
module tb_gshare_bht;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pred_valid = 1'b0;
    logic [8:0] pred_pc = '0;
    logic       upd_valid = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_mispredict = 1'b0;

    logic       a_pov, a_pred, b_pov, b_pred;
    logic [3:0] a_pidx, b_pidx, a_ghr, b_ghr;
    logic [15:0] a_supd, a_smis;
    logic [3:0]  b_supd, b_smis;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    gshare_bht #(.ENTRIES(16), .CTR_BITS(2), .PC_W(9), .HIST_BITS(4), .MODE(1), .STAT_W(16)) dut_a (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(a_pov), .prediction(a_pred), .pred_idx(a_pidx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ghr(a_ghr),
        .stat_updates(a_supd), .stat_mispredicts(a_smis)
    );

    gshare_bht #(.ENTRIES(16), .CTR_BITS(2), .PC_W(9), .HIST_BITS(4), .MODE(0), .STAT_W(4)) dut_b (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(b_pov), .prediction(b_pred), .pred_idx(b_pidx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ghr(b_ghr),
        .stat_updates(b_supd), .stat_mispredicts(b_smis)
    );

    // ---------------- behavioural model ----------------
    int ctr_m [16];
    int ghr_m;
    int supd_m [2];
    int smis_m [2];
    int stat_max [2] = '{65535, 15};
    bit pov_m;
    bit pred_m [2];
    int pidx_m [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) ctr_m[i] = 1;
            ghr_m = 0;
            pov_m = 0;
            for (int m = 0; m < 2; m++) begin
                pred_m[m] = 0; pidx_m[m] = 0; supd_m[m] = 0; smis_m[m] = 0;
            end
        end else begin
            pov_m = pred_valid;
            if (pred_valid) begin
                pidx_m[0] = (int'(pred_pc) % 16) ^ ghr_m;   // gshare
                pidx_m[1] = int'(pred_pc) % 16;             // bimodal
                for (int m = 0; m < 2; m++) pred_m[m] = (ctr_m[pidx_m[m]] >= 2);
            end
            if (upd_valid) begin
                if (upd_taken) ctr_m[upd_idx] = (ctr_m[upd_idx] < 3) ? ctr_m[upd_idx] + 1 : 3;
                else           ctr_m[upd_idx] = (ctr_m[upd_idx] > 0) ? ctr_m[upd_idx] - 1 : 0;
                ghr_m = (ghr_m * 2 + int'(upd_taken)) % 16;
                for (int m = 0; m < 2; m++) begin
                    if (supd_m[m] < stat_max[m]) supd_m[m]++;
                    if (upd_mispredict && smis_m[m] < stat_max[m]) smis_m[m]++;
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_pov", int'(a_pov), int'(pov_m));
            chk("b_pov", int'(b_pov), int'(pov_m));
            chk("a_pred", int'(a_pred), int'(pred_m[0]));
            chk("b_pred", int'(b_pred), int'(pred_m[1]));
            chk("a_pidx", int'(a_pidx), pidx_m[0]);
            chk("b_pidx", int'(b_pidx), pidx_m[1]);
            chk("a_ghr", int'(a_ghr), ghr_m);
            chk("b_ghr", int'(b_ghr), ghr_m);
            chk("a_supd", int'(a_supd), supd_m[0]);
            chk("a_smis", int'(a_smis), smis_m[0]);
            chk("b_supd", int'(b_supd), supd_m[1]);
            chk("b_smis", int'(b_smis), smis_m[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit pv, int pc, bit uv, int ui, bit ut, bit um);
        pred_valid     = pv;
        pred_pc        = pc[8:0];
        upd_valid      = uv;
        upd_idx        = ui[3:0];
        upd_taken      = ut;
        upd_mispredict = um;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic upd_n(int n, int ui, bit ut, bit um);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, ui, ut, um);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic predict_a(int pc, int exp_idx, int exp_pred, string tag);
        drive(1, pc, 0, 0, 0, 0);
        tick();
        chk({tag, "_idx"}, int'(a_pidx), exp_idx);
        chk({tag, "_pred"}, int'(a_pred), exp_pred);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tick(); tick();
        // Reset state
        chk("rst_pov", int'(a_pov), 0);
        chk("rst_ghr", int'(a_ghr), 0);
        chk("rst_supd", int'(a_supd), 0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // 1: first prediction, one-cycle latency
        drive(1, 5, 0, 0, 0, 0);
        tick();
        chk("t1_pov", int'(a_pov), 1);
        chk("t1_idx", int'(a_pidx), 5);
        chk("t1_pred", int'(a_pred), 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("t1_pov_drop", int'(a_pov), 0);

        // 2: two taken updates on idx 5, then gshare vs bimodal lookup of pc 6
        upd_n(2, 5, 1, 0);
        chk("t2_ghr", int'(a_ghr), 3);
        drive(1, 6, 0, 0, 0, 0);
        tick();
        chk("t2_a_idx", int'(a_pidx), 5);
        chk("t2_a_pred", int'(a_pred), 1);
        chk("t2_b_idx", int'(b_pidx), 6);
        chk("t2_b_pred", int'(b_pred), 0);
        drive(0, 0, 0, 0, 0, 0);

        // 3: saturation on idx 9 (ghr evolves 0011 -> 1111 -> 1110 -> 1000 -> 0000 -> 0001)
        upd_n(5, 9, 1, 0);
        upd_n(1, 9, 0, 0);
        chk("t3_ghr", int'(a_ghr), 14);
        predict_a(9 ^ 14, 9, 1, "t3_ctr2");
        upd_n(2, 9, 0, 0);
        predict_a(9 ^ 8, 9, 0, "t3_ctr0");
        upd_n(2, 9, 0, 0);
        upd_n(1, 9, 1, 0);
        predict_a(9 ^ 1, 9, 0, "t3_ctr1");

        // 4: same-cycle collision with no bypass
        upd_n(4, 15, 0, 0);
        chk("t4_ghr0", int'(a_ghr), 0);
        drive(1, 2, 1, 2, 1, 0);
        tick();
        chk("t4_col_idx", int'(a_pidx), 2);
        chk("t4_col_pred", int'(a_pred), 0);
        predict_a(3, 2, 1, "t4_next");

        // 5: statistics saturate (18 updates so far, none mispredicted)
        upd_n(20, 12, 0, 1);
        chk("t5_b_supd", int'(b_supd), 15);
        chk("t5_b_smis", int'(b_smis), 15);
        chk("t5_a_supd", int'(a_supd), 38);
        chk("t5_a_smis", int'(a_smis), 20);
        upd_n(1, 12, 1, 1);
        chk("t5_b_hold", int'(b_smis), 15);

        // Randomized phase, model checked every cycle
        for (int c = 0; c < 3000; c++) begin
            int ui;
            ui = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 511),
                  $urandom_range(0, 2) != 0, ui,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
            tick();
        end

        // 6: asynchronous reset mid-operation
        drive(1, 7, 1, 4, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_pre_pov", int'(a_pov), 1);
        chk("t6_pre_ghr_lsb", int'(a_ghr[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_pov", int'(a_pov), 0);
        chk("t6_pred", int'(a_pred), 0);
        chk("t6_idx", int'(a_pidx), 0);
        chk("t6_ghr", int'(a_ghr), 0);
        chk("t6_supd", int'(a_supd), 0);
        chk("t6_smis", int'(b_smis), 0);
        tick();
        reset = 1'b1;
        for (int p = 0; p < 16; p++) begin
            drive(1, p, 0, 0, 0, 0);
            tick();
            chk("t6_after_pred", int'(a_pred), 0);
            chk("t6_after_idx", int'(a_pidx), p);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gshare_bht.md
Name: gshare_bht

Overview:
Parametrised branch history table, the successor to the single-mode BHT. It holds ENTRIES saturating counters of CTR_BITS each and indexes them by PC alone (bimodal) or by PC XOR global history (gshare). Prediction and update are separate ports so a pipeline can resolve older branches while predicting new ones. It also keeps update and mispredict statistics for accuracy measurement.

Parameters:
ENTRIES, 16, number of counters; power of two, 4..1024; IDX_W = log2(ENTRIES)
CTR_BITS, 2, counter width, 1..4
PC_W, 9, PC width; PC_W >= IDX_W
HIST_BITS, 4, global history length, 1..IDX_W
MODE, 1, 0 = bimodal (pc index only), 1 = gshare
STAT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pred_valid  in  1  prediction request
pred_pc  in  PC_W  PC of the branch to predict
pred_out_valid  out  1  prediction result valid, 1 cycle after the request
prediction  out  1  1 = predict taken
pred_idx  out  IDX_W  table index used; the caller returns it on update
upd_valid  in  1  resolved-branch update
upd_idx  in  IDX_W  index returned from pred_idx
upd_taken  in  1  actual outcome
upd_mispredict  in  1  the earlier prediction was wrong
ghr  out  HIST_BITS  global history register
stat_updates  out  STAT_W  count of accepted updates
stat_mispredicts  out  STAT_W  count of updates with upd_mispredict=1

Behaviour:
- Reset (reset=0, async): every counter = 2^(CTR_BITS-1)-1, i.e. weakly not-taken (0 when CTR_BITS=1). ghr=0, pred_out_valid=0, prediction=0, pred_idx=0, both stats=0. Reset held low mid-operation clears everything immediately and discards in-flight requests.
- Index calculation:
  - MODE=1: idx = pred_pc[IDX_W-1:0] XOR zero_extend(ghr).
  - MODE=0: idx = pred_pc[IDX_W-1:0]; ghr is still maintained but not used for indexing.
- Prediction has 1-cycle latency. On a clk edge with pred_valid=1: pred_out_valid<=1, pred_idx<=idx, prediction<=MSB of counter[idx]. On a clk edge with pred_valid=0: pred_out_valid<=0, and prediction and pred_idx hold their previous values. A request is accepted every cycle; there is no backpressure.
- Update, on a clk edge with upd_valid=1:
  - counter[upd_idx] increments if upd_taken=1, saturating at 2^CTR_BITS-1.
  - counter[upd_idx] decrements if upd_taken=0, saturating at 0.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}, i.e. non-speculative history. When HIST_BITS=1, ghr <= upd_taken.
  - stat_updates increments; stat_mispredicts increments if upd_mispredict=1. Both saturate at all-ones and never wrap.
- Prediction and update in the same cycle: the index and counter read use the ghr and counter values from before that edge. There is no bypass, including when idx == upd_idx. The update becomes visible to requests from the next cycle onward.
- upd_idx is used as given and is never recomputed from a PC. Out-of-order updates are legal.
- All outputs are registered. No combinational path runs from inputs to outputs.

Test Plan:
(Defaults throughout, MODE=1, unless stated.)
1. Release reset; pred_valid=1, pred_pc=0x005 for one cycle -> next cycle pred_out_valid=1, pred_idx=5, prediction=0; the following cycle pred_out_valid=0.
2. Update idx 5 taken twice (counter 1->2->3, ghr=4'b0011); then predict pc=0x006 -> pred_idx=6^3=5, prediction=1. Repeat with MODE=0 -> pred_idx=6, prediction=0.
3. Saturation on idx 9:
   - 5 taken updates -> counter 3.
   - 1 not-taken -> 2, predicting idx 9 gives 1.
   - 2 more not-taken -> 0, prediction 0.
   - further not-taken leaves it at 0; one taken -> 1, prediction still 0.
4. Same-cycle collision: idx 2 counter=1 and ghr=0. In the same cycle, update idx 2 taken and predict pc=0x002 -> prediction=0 with pred_idx=2. Next cycle, predict pc=0x003 (ghr now 0001, idx 3^1=2) -> prediction=1.
5. With STAT_W=4: 20 updates, all with upd_mispredict=1 -> stat_updates=15 and stat_mispredicts=15, holding at those values.
6. Reset mid-operation: drive reset=0 asynchronously between edges while pred_out_valid=1 and ghr!=0 -> all outputs 0 immediately. After release, predicting every PC 0..15 gives prediction=0, confirming every counter is back at 1.
